// File: rtl/lamp_scan_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 active-low lamp decoder among 8 requesters.
// Each grant holds the decoder for hold_len+1 cycles, followed by one disabled gap cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no requester, decoder disabled
// ST_GRANT | grant_idx owns the decoder, hold counter running
// ST_GAP   | one dead cycle with decoder disabled, done pulse high
module lamp_scan_arbiter #(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        req,
    input  logic [HOLD_W-1:0] hold_len,
    output logic              sel_c,
    output logic              sel_b,
    output logic              sel_a,
    output logic              dec_g,
    output logic              dec_g2a,
    output logic              dec_g2b,
    output logic              grant_valid,
    output logic [2:0]        grant_idx,
    output logic              done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [HOLD_W-1:0] CNT_ONE = HOLD_W'(1);

    logic [1:0]        state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        last_q, last_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              gv_q, gv_d;
    logic              done_q, done_d;
    logic              dec_g_q, dec_g_d;
    logic              g2a_q, g2a_d;
    logic              g2b_q, g2b_d;

    logic              win_found;
    logic [2:0]        win_idx;
    logic [2:0]        cand;

    // Search starts one past the last winner; offset 8 wraps back onto last_q itself,
    // which lets a sole continuous requester win again.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int k = 1; k <= 8; k++) begin
            cand = last_q + 3'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gv_d    = gv_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_GRANT;
                    idx_d   = win_idx;
                    last_d  = win_idx;
                    cnt_d   = hold_len;
                    gv_d    = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!req[idx_q] || (cnt_q == '0)) begin
                    state_d = ST_GAP;
                    gv_d    = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                done_d = 1'b0;
                if (win_found) begin
                    state_d = ST_GRANT;
                    idx_d   = win_idx;
                    last_d  = win_idx;
                    cnt_d   = hold_len;
                    gv_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gv_d    = 1'b0;
                done_d  = 1'b0;
            end
        endcase
        dec_g_d = (state_d == ST_GRANT);
        g2a_d   = ~dec_g_d;
        g2b_d   = ~dec_g_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            last_q  <= 3'd7;
            cnt_q   <= '0;
            gv_q    <= 1'b0;
            done_q  <= 1'b0;
            dec_g_q <= 1'b0;
            g2a_q   <= 1'b1;
            g2b_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gv_q    <= gv_d;
            done_q  <= done_d;
            dec_g_q <= dec_g_d;
            g2a_q   <= g2a_d;
            g2b_q   <= g2b_d;
        end
    end

    assign sel_c       = idx_q[2];
    assign sel_b       = idx_q[1];
    assign sel_a       = idx_q[0];
    assign grant_idx   = idx_q;
    assign grant_valid = gv_q;
    assign done        = done_q;
    assign dec_g       = dec_g_q;
    assign dec_g2a     = g2a_q;
    assign dec_g2b     = g2b_q;

endmodule

// File: tb/tb_lamp_scan_arbiter.sv
// Scoreboard bench for lamp_scan_arbiter: stimulus queues expected grants,
// a negedge monitor pops and checks each grant as the DUT presents it.
module tb_lamp_scan_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] hold_len = 8'h00;
    logic       sel_c, sel_b, sel_a;
    logic       dec_g, dec_g2a, dec_g2b;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       done;

    lamp_scan_arbiter #(.HOLD_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .hold_len   (hold_len),
        .sel_c      (sel_c),
        .sel_b      (sel_b),
        .sel_a      (sel_a),
        .dec_g      (dec_g),
        .dec_g2a    (dec_g2a),
        .dec_g2b    (dec_g2b),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .done       (done)
    );

    always #5 clk = ~clk;

    // len/gap of -1 mean "do not check"
    typedef struct {
        int idx;
        int len;
        int gap;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    bit   m_prev_gv = 1'b0;
    bit   m_have = 1'b0;
    int   m_len = 0;
    int   m_gap = 0;
    exp_t m_cur;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input int idx, input int len, input int gap);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic wait_gv(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (grant_valid) got = 1'b1;
        end
        chk("wait_grant_timeout", int'(got), 1);
    endtask

    task automatic wait_done(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("wait_done_timeout", int'(got), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant_valid"}, int'(grant_valid), 0);
        chk({tag, "_dec_en"}, int'({dec_g, dec_g2a, dec_g2b}), 3);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_grant_idx"}, int'(grant_idx), 0);
        chk({tag, "_sel_cba"}, int'({sel_c, sel_b, sel_a}), 0);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_prev_gv = 1'b0;
                m_have    = 1'b0;
                m_gap     = 0;
            end else begin
                if (grant_valid) begin
                    if (!m_prev_gv) begin
                        m_len = 1;
                        chk("sb_expected_grant", int'(sb_q.size() > 0), 1);
                        if (sb_q.size() > 0) begin
                            m_cur  = sb_q.pop_front();
                            m_have = 1'b1;
                            chk("grant_idx", int'(grant_idx), m_cur.idx);
                            if (m_cur.gap >= 0) chk("gap_len", m_gap, m_cur.gap);
                        end
                    end else begin
                        m_len++;
                    end
                    if (m_have) chk("sel_cba", int'({sel_c, sel_b, sel_a}), m_cur.idx);
                    chk("dec_en_grant", int'({dec_g, dec_g2a, dec_g2b}), 4);
                    chk("done_in_grant", int'(done), 0);
                end else begin
                    chk("dec_en_off", int'({dec_g, dec_g2a, dec_g2b}), 3);
                    if (m_prev_gv) begin
                        chk("done_pulse", int'(done), 1);
                        if (m_have && m_cur.len >= 0) chk("grant_len", m_len, m_cur.len);
                        m_have = 1'b0;
                        m_gap  = 1;
                    end else begin
                        chk("done_idle", int'(done), 0);
                        m_gap++;
                    end
                end
                m_prev_gv = grant_valid;
            end
        end
    end

    // Stimulus
    initial begin
        @(negedge clk);
        chk_reset_outputs("reset");
        #2 rst = 1'b0;

        // sole requester 0, hold 2: re-granted after one gap
        @(negedge clk);
        push(0, 3, -1);
        push(0, 3, 1);
        hold_len = 8'd2;
        req = 8'h01;
        wait_done(50);
        wait_done(50);
        req = 8'h00;
        repeat (2) @(negedge clk);

        // from reset, req 0 and 7 alternate with 1-cycle grants
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        push(0, 1, -1);
        push(7, 1, 1);
        push(0, 1, 1);
        push(7, 1, 1);
        hold_len = 8'd0;
        req = 8'h81;
        for (int i = 0; i < 4; i++) wait_done(50);
        req = 8'h00;
        repeat (2) @(negedge clk);

        // grant 6, then req 0 and 6 together: search wraps past 7 to 0
        push(6, 1, -1);
        push(0, 1, 1);
        req = 8'h40;
        wait_done(50);
        req = 8'h41;
        wait_done(50);
        req = 8'h00;
        repeat (2) @(negedge clk);

        // early release of channel 3 after 2 grant cycles
        push(3, 2, -1);
        hold_len = 8'd10;
        req = 8'h08;
        wait_gv(50);
        @(negedge clk);
        req = 8'h00;
        wait_done(50);
        repeat (2) @(negedge clk);

        // reset asserted in the second cycle of a grant
        push(2, -1, -1);
        hold_len = 8'd5;
        req = 8'h04;
        wait_gv(50);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_reset");
        hold_len = 8'd0;
        req = 8'h10;
        push(4, 1, -1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        wait_done(50);
        req = 8'h00;
        repeat (2) @(negedge clk);

        // hold_len changed mid-grant only affects the next grant
        push(5, 2, -1);
        push(5, 8, 1);
        hold_len = 8'd1;
        req = 8'h20;
        wait_gv(50);
        hold_len = 8'd7;
        wait_done(50);
        wait_done(50);
        req = 8'h00;
        repeat (2) @(negedge clk);

        // all-ones hold, other requesters may not preempt
        push(1, 256, -1);
        hold_len = 8'hFF;
        req = 8'h02;
        wait_gv(50);
        req = 8'h83;
        wait_done(400);
        req = 8'h00;

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("idle_grant_idx_hold", int'(grant_idx), 1);
        chk("idle_sel_hold", int'({sel_c, sel_b, sel_a}), 1);
        chk("idle_grant_valid", int'(grant_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lamp_scan_arbiter.md
Name: lamp_scan_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 active-low lamp decoder among 8 requesters.
- Picks one requester, drives the decoder select lines (C,B,A) and enables (G, G2A, G2B) for a programmable hold time, then inserts a one-cycle dead gap with the decoder disabled.
- Sits between the lamp request logic and the 74LS138-style decoder instance in the lamp control design.

Parameters:
- HOLD_W, 8, width of the hold_len input and the internal hold counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request per lamp channel; req[i] high = channel i wants the decoder.
- hold_len  input  HOLD_W  grant length minus one; sampled only when a grant is issued.
- sel_c  output  1  decoder select MSB (C) = grant_idx[2].
- sel_b  output  1  decoder select (B) = grant_idx[1].
- sel_a  output  1  decoder select LSB (A) = grant_idx[0].
- dec_g  output  1  decoder G enable, active-high.
- dec_g2a  output  1  decoder G2A enable, active-low.
- dec_g2b  output  1  decoder G2B enable, active-low.
- grant_valid  output  1  high while a channel owns the decoder.
- grant_idx  output  3  index of the current or most recent grant.
- done  output  1  one-cycle pulse marking the end of a grant.

Behaviour:
- Reset: asynchronous, active-high. Applies immediately, including mid-grant, with no gap cycle. Reset values:
  - state = IDLE, grant_idx = 0, sel_c/sel_b/sel_a = 0.
  - dec_g = 0, dec_g2a = 1, dec_g2b = 1.
  - grant_valid = 0, done = 0, hold counter = 0.
  - last pointer = 7, so the first search starts at channel 0.
- All outputs are registered.
- Decoder enables are driven from state:
  - GRANT: dec_g = 1, dec_g2a = 0, dec_g2b = 0.
  - Any other state: dec_g = 0, dec_g2a = 1, dec_g2b = 1.
  - Result: exactly one decoder output is low only during GRANT, and all outputs are high otherwise.
- Arbitration (combinational winner):
  - Search req from index (last+1) mod 8 upward, wrapping past 7 to 0.
  - The first set bit wins.
  - If req == 0, there is no winner.
- States:
  - IDLE:
    - At an edge with req != 0: go to GRANT, grant_idx <= winner, last <= winner, cnt <= hold_len, grant_valid <= 1.
    - Otherwise stay in IDLE.
  - GRANT:
    - At each edge, if req[grant_idx] == 0 (early release) or cnt == 0: go to GAP, grant_valid <= 0, done <= 1.
    - Otherwise cnt <= cnt - 1.
  - GAP: lasts exactly one cycle; done is high during this cycle. At the next edge:
    - done <= 0.
    - If req != 0: arbitrate and go to GRANT, with the same updates as from IDLE.
    - Otherwise go to IDLE.
- Timing:
  - A full grant lasts hold_len+1 cycles.
  - Latency from req rising (sampled in IDLE) to grant_valid is 1 edge.
  - Back-to-back grants are separated by exactly 1 gap cycle.
- Boundary conditions:
  - hold_len = 0: 1-cycle grant.
  - hold_len = all-ones: 2^HOLD_W cycles.
  - hold_len changes during GRANT are ignored.
  - Early release takes priority over cnt.
  - Requests from other channels during GRANT do not preempt the current grant.
  - A sole continuous requester is re-granted after every gap (it wins the search via wrap-around).
  - grant_idx and sel_* hold their last value in GAP and IDLE.

Test Plan:
- Reset, then req=8'h01, hold_len=2 -> grant_valid high 3 cycles with grant_idx=0 and dec_g/g2a/g2b = 1/0/0; done pulses 1 cycle; 1 gap cycle with enables off; grant to 0 again.
- req=8'h81, hold_len=0 held constant -> grant sequence 0,7,0,7; each grant 1 cycle; 1 gap cycle between grants; done high in every gap.
- Force last=6 via a prior grant to channel 6, then req=8'h41 -> next grant is channel 0 (wraps past 7), not 6.
- Grant channel 3 with hold_len=10; drop req[3] after 2 grant cycles -> GAP on the next edge; done pulses; grant_valid falls early.
- Assert rst mid-GRANT (hold_len=5, cycle 2) -> outputs take reset values immediately (dec_g2a=1, grant_valid=0); after release with req=8'h10, first grant goes to channel 4.
- Change hold_len from 1 to 7 during a grant -> the current grant still lasts 2 cycles; the next grant lasts 8 cycles.
